// File: rtl/xor_sched_pkg.sv
// Shared types and constants for the bit-serial XOR round-robin scheduler.
package xor_sched_pkg;

    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Winner between two requesters: the pointer breaks ties, else the lone requester wins.
    function automatic logic rr_pick(input logic [NUM_REQ-1:0] valid, input logic ptr);
        if (&valid) begin
            return ptr;
        end
        return valid[1];
    endfunction

endpackage

// File: rtl/xor_bit_cell.sv
// Single-bit XOR cell shared by every bit position of the serial datapath.
module xor_bit_cell (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

// File: rtl/xor_rr_scheduler.sv
// Two-requester round-robin front end feeding a bit-serial XOR engine;
// one operation in flight, result held until the consumer takes it.
module xor_rr_scheduler
    import xor_sched_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    input  logic [W-1:0]       req0_a,
    input  logic [W-1:0]       req0_b,
    input  logic [W-1:0]       req1_a,
    input  logic [W-1:0]       req1_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [W-1:0]       rsp_data,
    output logic               rsp_id,
    output logic               busy
);

    localparam int unsigned   CW       = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    rsp_data_q, rsp_data_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            owner_q, owner_d;
    logic            ptr_q, ptr_d;
    logic            rsp_id_q, rsp_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            busy_q, busy_d;
    logic            grant_c;
    logic            bit_y;

    xor_bit_cell u_xor_bit_cell (
        .a (a_q[0]),
        .b (b_q[0]),
        .y (bit_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            rsp_data_q  <= '0;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            ptr_q       <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            rsp_data_q  <= rsp_data_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        rsp_data_d  = rsp_data_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
        req_ready   = '0;
        grant_c     = rr_pick(req_valid, ptr_q);

        case (state_q)
            ST_IDLE: begin
                // Ready is held low during reset so nothing can look accepted.
                if (rst_n && req_valid[grant_c]) begin
                    req_ready[grant_c] = 1'b1;
                    a_d     = grant_c ? req1_a : req0_a;
                    b_d     = grant_c ? req1_b : req0_b;
                    owner_d = grant_c;
                    cnt_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                acc_d = {bit_y, acc_q[W-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = acc_d;
                    rsp_id_d    = owner_q;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = '0;
                    busy_d      = 1'b0;
                    ptr_d       = ~rsp_id_q;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_xor_rr_scheduler.sv
// Randomized self-checking bench for xor_rr_scheduler against a transaction-level model.
module tb_xor_rr_scheduler;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_id;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int ptr_m  = 0;
    int g_last = 0;

    always #5 clk = ~clk;

    xor_rr_scheduler #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic scramble_inputs();
        req_valid = 2'($urandom);
        req0_a    = W'($urandom);
        req0_b    = W'($urandom);
        req1_a    = W'($urandom);
        req1_b    = W'($urandom);
    endtask

    // One full operation: request, serial run, response held for 'hold' cycles, release.
    task automatic run_op(input logic [1:0] vmask, input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1, input int hold);
        int           g;
        int           edges;
        logic [W-1:0] exp;
        logic [1:0]   exp_rdy;
        req_valid = vmask;
        req0_a    = a0;
        req0_b    = b0;
        req1_a    = a1;
        req1_b    = b1;
        rsp_ready = 1'($urandom);
        #1;
        g       = (vmask == 2'b11) ? ptr_m : (vmask[1] ? 1 : 0);
        exp     = (g == 1) ? (a1 ^ b1) : (a0 ^ b0);
        exp_rdy = (g == 1) ? 2'b10 : 2'b01;
        check_eq("idle_ready", 32'(req_ready), 32'(exp_rdy));
        check_eq("idle_busy_valid", 32'({busy, rsp_valid}), 32'(0));
        @(posedge clk);
        edges = 0;
        for (int k = 0; k < int'(W) + 4; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
            check_eq("run_quiet", 32'({busy, req_ready, rsp_data}), 32'({1'b1, 2'b00, {W{1'b0}}}));
            scramble_inputs();
            rsp_ready = (edges == int'(W) - 1 && hold == 0) ? 1'b1 : 1'($urandom);
            @(posedge clk);
            edges++;
        end
        check_eq("latency", 32'(edges), 32'(W));
        check_eq("rsp_data", 32'(rsp_data), 32'(exp));
        check_eq("rsp_id", 32'(rsp_id), 32'(g));
        check_eq("done_ready", 32'({busy, req_ready}), 32'(3'b100));
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            req_valid = 2'($urandom);
            @(posedge clk);
            @(negedge clk);
            check_eq("hold_out", 32'({rsp_valid, busy, req_ready, rsp_id, rsp_data}),
                     32'({1'b1, 1'b1, 2'b00, 1'(g), exp}));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 2'b00;
        #1;
        check_eq("release", 32'({rsp_valid, busy, req_ready, rsp_data}), 32'(0));
        ptr_m  = 1 - g;
        g_last = g;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req0_a    = '0;
        req0_b    = '0;
        req1_a    = '0;
        req1_b    = '0;
        rsp_ready = 1'b1;
        #3;
        check_eq("reset_out", 32'({req_ready, rsp_valid, rsp_id, busy, rsp_data}), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Both requesters asserted from reset alternate 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            run_op(2'b11, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 0);
        end

        run_op(2'b01, 8'hA5, 8'h0F, W'($urandom), W'($urandom), 0);
        run_op(2'b10, W'($urandom), W'($urandom), 8'h12, 8'h34, 5);
        run_op(2'b01, 8'hFF, 8'hFF, 8'h00, 8'h00, 1);
        run_op(2'b10, 8'h00, 8'h00, 8'h00, 8'hFF, 0);

        for (int i = 0; i < 20; i++) begin
            run_op(2'($urandom_range(1, 3)), W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                   int'($urandom_range(0, 3)));
        end

        // No request, then a request withdrawn before any edge: nothing starts.
        req_valid = 2'b00;
        #1;
        check_eq("none_ready", 32'(req_ready), 32'(0));
        req_valid = 2'b01;
        #1;
        check_eq("single_ready", 32'(req_ready), 32'(2'b01));
        req_valid = 2'b00;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("withdrawn_idle", 32'({busy, rsp_valid}), 32'(0));

        // Leave the pointer at requester 1, then abort an operation with reset.
        run_op(2'b01, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 0);
        req_valid = 2'b01;
        req0_a    = 8'h5A;
        req0_b    = 8'h11;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        #1;
        check_eq("abort_out", 32'({req_ready, rsp_valid, rsp_id, busy, rsp_data}), 32'(0));
        @(negedge clk);
        check_eq("abort_hold", 32'({req_ready, rsp_valid, busy, rsp_data}), 32'(0));
        rst_n     = 1'b1;
        req_valid = 2'b00;
        ptr_m     = 0;
        #1;
        run_op(2'b11, W'($urandom), W'($urandom), W'($urandom), W'($urandom), 0);
        run_op(2'b10, W'($urandom), W'($urandom), 8'h3C, 8'hC3, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
